// File: rtl/rvv_backend_alu_result_pipe.sv
// Result-staging pipeline for vector ALU units: merges one-hot sub-unit results
// into one ROB write port, holding 2-cycle and backpressured results in issue order.
module rvv_backend_alu_result_pipe #(
  parameter  int NUM_SRC = 4,
  parameter  int DATA_W  = 128,
  parameter  int TAG_W   = 8,
  parameter  int VSAT_W  = DATA_W / 8,
  parameter  int DEPTH   = 2,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      trap_flush_rvv,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_2cycle,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*VSAT_W-1:0] src_vsat,
  output logic                      pop_rs,
  output logic [DATA_W-1:0]         p1_data,
  input  logic [DATA_W-1:0]         p1_result,
  output logic                      result_valid,
  output logic [TAG_W-1:0]          result_tag,
  output logic [DATA_W-1:0]         result_data,
  output logic [VSAT_W-1:0]         result_vsat,
  input  logic                      result_ready,
  output logic                      multi_src_err,
  output logic [CNT_W-1:0]          q_count
);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic [VSAT_W-1:0] vsat;
    logic              needs_p1;
  } entry_t;

  entry_t            mem_q [DEPTH];
  entry_t            entry_d;
  entry_t            head;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              in_valid;
  logic              sel_2c;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic [VSAT_W-1:0] sel_vsat;
  logic              q_empty, q_full;
  logic              direct_fire, deq_fire, enq_fire;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Source select: lowest-index valid source wins
  always_comb begin
    in_valid = 1'b0;
    sel_2c   = 1'b0;
    sel_tag  = '0;
    sel_data = '0;
    sel_vsat = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_valid[i] && !in_valid) begin
        in_valid = 1'b1;
        sel_2c   = src_2cycle[i];
        sel_tag  = src_tag[i*TAG_W +: TAG_W];
        sel_data = src_data[i*DATA_W +: DATA_W];
        sel_vsat = src_vsat[i*VSAT_W +: VSAT_W];
      end
    end
  end

  assign multi_src_err = |(src_valid & (src_valid - NUM_SRC'(1)));

  assign head    = mem_q[rd_ptr_q];
  assign q_empty = (count_q == '0);
  assign q_full  = (count_q == CNT_W'(DEPTH));

  // A flush cycle suppresses every handshake so nothing moves while the queue is cleared
  assign deq_fire    = !trap_flush_rvv && !q_empty && result_ready;
  assign direct_fire = !trap_flush_rvv && q_empty && in_valid && !sel_2c && result_ready;
  assign enq_fire    = !trap_flush_rvv && in_valid && !direct_fire && (!q_full || deq_fire);
  assign pop_rs      = direct_fire || enq_fire;

  always_comb begin
    result_valid = 1'b0;
    result_tag   = '0;
    result_data  = '0;
    result_vsat  = '0;
    p1_data      = '0;
    if (!q_empty) begin
      p1_data = head.data;
    end
    if (!trap_flush_rvv) begin
      if (!q_empty) begin
        result_valid = 1'b1;
        result_tag   = head.tag;
        result_vsat  = head.vsat;
        result_data  = head.needs_p1 ? p1_result : head.data;
      end else if (in_valid && !sel_2c) begin
        result_valid = 1'b1;
        result_tag   = sel_tag;
        result_vsat  = sel_vsat;
        result_data  = sel_data;
      end
    end
  end

  always_comb begin
    entry_d = '{tag: sel_tag, data: sel_data, vsat: sel_vsat, needs_p1: sel_2c};
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (trap_flush_rvv) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (deq_fire) rd_ptr_d = ptr_inc(rd_ptr_q);
      if (enq_fire) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage boundary (data only, not reset)
  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= entry_d;
  end

  assign q_count = count_q;

endmodule

// File: tb/tb_rvv_backend_alu_result_pipe.sv
// Directed bench for rvv_backend_alu_result_pipe (defaults: 4 sources, 128b data, depth 2).
module tb_rvv_backend_alu_result_pipe;

  localparam int NS = 4;
  localparam int DW = 128;
  localparam int TW = 8;
  localparam int VW = DW / 8;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            trap_flush_rvv;
  logic [NS-1:0]   src_valid, src_2cycle;
  logic [NS*TW-1:0] src_tag;
  logic [NS*DW-1:0] src_data;
  logic [NS*VW-1:0] src_vsat;
  logic            pop_rs;
  logic [DW-1:0]   p1_data, p1_result;
  logic            result_valid;
  logic [TW-1:0]   result_tag;
  logic [DW-1:0]   result_data;
  logic [VW-1:0]   result_vsat;
  logic            result_ready;
  logic            multi_src_err;
  logic [CW-1:0]   q_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign p1_result = ~p1_data;

  rvv_backend_alu_result_pipe dut (
    .clk(clk), .rst_n(rst_n), .trap_flush_rvv(trap_flush_rvv),
    .src_valid(src_valid), .src_2cycle(src_2cycle), .src_tag(src_tag),
    .src_data(src_data), .src_vsat(src_vsat), .pop_rs(pop_rs),
    .p1_data(p1_data), .p1_result(p1_result), .result_valid(result_valid),
    .result_tag(result_tag), .result_data(result_data), .result_vsat(result_vsat),
    .result_ready(result_ready), .multi_src_err(multi_src_err), .q_count(q_count)
  );

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    src_valid  = '0;
    src_2cycle = '0;
    src_tag    = '0;
    src_data   = '0;
    src_vsat   = '0;
  endtask

  task automatic drive(input int s, input logic two, input logic [TW-1:0] tag, input logic [DW-1:0] data);
    idle();
    src_valid[s]            = 1'b1;
    src_2cycle[s]           = two;
    src_tag[s*TW +: TW]     = tag;
    src_data[s*DW +: DW]    = data;
    src_vsat[s*VW +: VW]    = VW'(tag);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [TW-1:0] t;
    rst_n = 1'b0;
    trap_flush_rvv = 1'b0;
    result_ready = 1'b0;
    idle();

    // reset state
    @(negedge clk);
    chk("rst_valid", DW'(result_valid), '0);
    chk("rst_pop", DW'(pop_rs), '0);
    chk("rst_count", DW'(q_count), '0);
    chk("rst_data", result_data, '0);
    chk("rst_multi", DW'(multi_src_err), '0);
    rst_n = 1'b1;
    next_cyc();

    // direct path
    result_ready = 1'b1;
    drive(0, 1'b0, 8'd5, 128'hA5);
    @(negedge clk);
    chk("dir_valid", DW'(result_valid), 1);
    chk("dir_tag", DW'(result_tag), 5);
    chk("dir_data", result_data, 128'hA5);
    chk("dir_vsat", DW'(result_vsat), 5);
    chk("dir_pop", DW'(pop_rs), 1);
    next_cyc();
    idle();
    @(negedge clk);
    chk("dir_count", DW'(q_count), 0);
    next_cyc();

    // two-cycle through stage-1 transform
    drive(2, 1'b1, 8'd9, 128'h1234);
    @(negedge clk);
    chk("2c_pop0", DW'(pop_rs), 1);
    chk("2c_valid0", DW'(result_valid), 0);
    next_cyc();
    idle();
    @(negedge clk);
    chk("2c_valid1", DW'(result_valid), 1);
    chk("2c_tag1", DW'(result_tag), 9);
    chk("2c_data1", result_data, ~128'h1234);
    chk("2c_count1", DW'(q_count), 1);
    next_cyc();
    @(negedge clk);
    chk("2c_count2", DW'(q_count), 0);
    chk("2c_valid2", DW'(result_valid), 0);
    next_cyc();

    // ordering under backpressure
    result_ready = 1'b0;
    drive(1, 1'b1, 8'd1, 128'h11);
    @(negedge clk);
    chk("ord_pop1", DW'(pop_rs), 1);
    next_cyc();
    drive(0, 1'b0, 8'd2, 128'h22);
    @(negedge clk);
    chk("ord_pop2", DW'(pop_rs), 1);
    chk("ord_head1", DW'(result_tag), 1);
    next_cyc();
    drive(3, 1'b0, 8'd3, 128'h33);
    @(negedge clk);
    chk("ord_pop3_blocked", DW'(pop_rs), 0);
    chk("ord_count2", DW'(q_count), 2);
    result_ready = 1'b1;
    #1;
    chk("ord_pop3", DW'(pop_rs), 1);
    chk("ord_tag1", DW'(result_tag), 1);
    chk("ord_data1", result_data, ~128'h11);
    next_cyc();
    idle();
    @(negedge clk);
    chk("ord_tag2", DW'(result_tag), 2);
    chk("ord_data2", result_data, 128'h22);
    chk("ord_cnt_a", DW'(q_count), 2);
    next_cyc();
    @(negedge clk);
    chk("ord_tag3", DW'(result_tag), 3);
    chk("ord_data3", result_data, 128'h33);
    chk("ord_cnt_b", DW'(q_count), 1);
    next_cyc();
    @(negedge clk);
    chk("ord_cnt_c", DW'(q_count), 0);
    next_cyc();

    // full queue with simultaneous enqueue/dequeue, pointer wrap
    result_ready = 1'b0;
    drive(0, 1'b0, 8'd40, 128'd40);
    next_cyc();
    drive(0, 1'b1, 8'd41, 128'd41);
    next_cyc();
    result_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      t = 8'(42 + i);
      drive(i % NS, t[0], t, DW'(t));
      @(negedge clk);
      t = 8'(40 + i);
      chk("full_pop", DW'(pop_rs), 1);
      chk("full_tag", DW'(result_tag), DW'(t));
      chk("full_data", result_data, t[0] ? ~DW'(t) : DW'(t));
      chk("full_count", DW'(q_count), 2);
      next_cyc();
    end
    idle();
    @(negedge clk);
    chk("drain_tag46", DW'(result_tag), 46);
    next_cyc();
    @(negedge clk);
    chk("drain_tag47", DW'(result_tag), 47);
    chk("drain_data47", result_data, ~DW'(47));
    next_cyc();
    @(negedge clk);
    chk("drain_count", DW'(q_count), 0);
    next_cyc();

    // flush
    result_ready = 1'b0;
    drive(0, 1'b0, 8'd50, 128'd50);
    next_cyc();
    drive(0, 1'b1, 8'd51, 128'd51);
    next_cyc();
    drive(0, 1'b0, 8'd52, 128'd52);
    trap_flush_rvv = 1'b1;
    @(negedge clk);
    chk("fl_count_pre", DW'(q_count), 2);
    chk("fl_valid", DW'(result_valid), 0);
    chk("fl_pop", DW'(pop_rs), 0);
    next_cyc();
    trap_flush_rvv = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    chk("fl_count", DW'(q_count), 0);
    chk("fl_dir_valid", DW'(result_valid), 1);
    chk("fl_dir_tag", DW'(result_tag), 52);
    chk("fl_dir_pop", DW'(pop_rs), 1);
    next_cyc();
    idle();

    // multi-source select
    src_valid = 4'b0110;
    src_tag[1*TW +: TW] = 8'd61;
    src_data[1*DW +: DW] = 128'd61;
    src_tag[2*TW +: TW] = 8'd62;
    src_data[2*DW +: DW] = 128'd62;
    @(negedge clk);
    chk("ms_err", DW'(multi_src_err), 1);
    chk("ms_tag", DW'(result_tag), 61);
    chk("ms_data", result_data, 128'd61);
    next_cyc();
    idle();

    // asynchronous reset mid-queue
    result_ready = 1'b0;
    drive(3, 1'b1, 8'd70, 128'd70);
    next_cyc();
    idle();
    @(negedge clk);
    chk("ar_count_pre", DW'(q_count), 1);
    chk("ar_valid_pre", DW'(result_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_count", DW'(q_count), 0);
    chk("ar_valid", DW'(result_valid), 0);
    next_cyc();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rvv_backend_alu_result_pipe.md
# rvv_backend_alu_result_pipe

Parametrised result-staging pipeline for vector ALU execution units. It merges one-hot results from `NUM_SRC` combinational sub-units, such as addsub, shift, mask and other, into a single ROB write port. Results that need a second cycle are buffered in a `DEPTH`-entry in-order queue that feeds an external stage-1 transform. The block sits between the ALU reservation-station pop and the ROB result port, and it keeps results in issue order under ROB backpressure and trap flush.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of p0 result sources.
- `DATA_W`, default 128: result data width in bits.
- `TAG_W`, default 8: ROB entry tag width.
- `VSAT_W`, default `DATA_W/8`: saturation-flag width.
- `DEPTH`, default 2: staging queue entries; must be ≥1; need not be a power of 2.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `trap_flush_rvv`  in  1: synchronous flush of all staged results.
- `src_valid`  in  NUM_SRC: per-source p0 result valid.
- `src_2cycle`  in  NUM_SRC: the source's result needs the stage-1 transform.
- `src_tag`  in  NUM_SRC*TAG_W: per-source ROB tag, packed with source 0 at the LSBs.
- `src_data`  in  NUM_SRC*DATA_W: per-source data.
- `src_vsat`  in  NUM_SRC*VSAT_W: per-source saturation flags.
- `pop_rs`  out  1: the current RS uop is consumed this cycle.
- `p1_data`  out  DATA_W: queue-head data, driven to the external stage-1 transform.
- `p1_result`  in  DATA_W: combinational transform result for `p1_data`.
- `result_valid`  out  1: ROB write valid.
- `result_tag`  out  TAG_W: ROB tag.
- `result_data`  out  DATA_W: ROB data.
- `result_vsat`  out  VSAT_W: ROB saturation flags.
- `result_ready`  in  1: ROB accepts the result.
- `multi_src_err`  out  1: more than one `src_valid` bit is set in this cycle.
- `q_count`  out  $clog2(DEPTH+1): number of occupied queue entries.

## Operation
- `in_valid = |src_valid`. The selected source `sel` is the lowest-index valid source. Other valid sources are ignored, and `multi_src_err` is high for that cycle.
- Each queue entry holds {tag, data, vsat, needs_p1}. The queue has a read pointer, a write pointer and a count. Both pointers wrap from `DEPTH-1` to 0.
- Output mux:
  - When the queue is non-empty, the head drives the output:
    - `result_valid=1`.
    - `result_tag` and `result_vsat` come from the head.
    - `result_data` is `p1_result` if `needs_p1` is set, else the stored data.
  - When the queue is empty and `in_valid & !src_2cycle[sel]`, the direct path drives the output: `result_valid=1` with the `sel` fields.
  - Otherwise `result_valid=0`.
- `p1_data` always carries the head's data; it is don't-care when the queue is empty.
- Dequeue fires when the queue is non-empty and `result_ready` is high.
- Direct path fires when the queue is empty, `in_valid & !src_2cycle[sel]` and `result_ready` are all high. In that case `pop_rs=1` and nothing is enqueued.
- Enqueue fires when `in_valid`, the direct path is not taken, and `(count<DEPTH) | dequeue` holds. In that case `pop_rs=1` and {sel fields, needs_p1=`src_2cycle[sel]`} is pushed.
- Ordering: a single-cycle result never bypasses a non-empty queue. It is enqueued with `needs_p1=0`.
- `pop_rs=0` otherwise. The RS holds the uop stable until `pop_rs`.
- A simultaneous enqueue and dequeue while full is legal; the count is unchanged.

## Timing
- Reset: count=0 and pointers=0. With an empty queue and `src_valid=0`, all outputs are 0. Queue data contents are don't-care.
- Direct-path latency is 0 cycles (combinational from `src_*` to `result_*`). A queued result is visible one cycle after its enqueue edge at the earliest.
- Throughput is one result per cycle in steady state with `result_ready` held high, including back-to-back 2-cycle uops.
- `trap_flush_rvv` clears count and pointers at the next edge. During the flush cycle, `pop_rs=0` and `result_valid=0`, and no enqueue or dequeue takes effect.
- If reset is asserted mid-operation, queued results are discarded immediately (asynchronous reset).
- `q_count` is registered and updates at the clock edge after an enqueue or dequeue.

## Test plan
- **Direct path:** source 0 valid, `2cycle=0`, tag=5, data=0xA5, `result_ready=1`.
  - Same cycle: `result_valid=1`, tag 5, data 0xA5, `pop_rs=1`.
  - `q_count` stays 0.
- **Two-cycle:** source 2 valid, `2cycle=1`, tag=9, with `p1_result = ~p1_data`.
  - Cycle 0: `pop_rs=1`, `result_valid=0`.
  - Cycle 1: `result_valid=1`, tag 9, data `~data`.
- **Ordering under backpressure:** `DEPTH=2`, `result_ready=0`; present a 2-cycle uop (tag 1) then a 1-cycle uop (tag 2).
  - Both enqueue; `q_count=2`.
  - A third uop sees `pop_rs=0`.
  - After `result_ready=1`: tags emerge in order 1, 2, 3 on consecutive cycles.
- **Full plus simultaneous events:** queue full and `result_ready=1` with a new uop present.
  - Same cycle: dequeue and enqueue both occur, `pop_rs=1`, `q_count` stays 2.
  - Pointers wrap correctly over 5 or more iterations.
- **Flush:** queue holds 2 entries; pulse `trap_flush_rvv` with `src_valid=1`.
  - During the flush cycle: `result_valid=0`, `pop_rs=0`.
  - Next cycle: `q_count=0`.
  - Then the held uop follows the direct path.
- **Multi-source and reset:** `src_valid=4'b0110`.
  - Source 1 is selected and `multi_src_err=1`.
  - Assert `rst_n=0` mid-queue: `q_count=0` and `result_valid=0` immediately.
